seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial bit-pattern transmitter. It is the driving end for the team's serial sequence detectors.
- On a start request it latches a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock, repeated a programmable number of times.
- An optional idle gap can be inserted between repetitions.
- It sits upstream of a detector on the same single-bit line and feeds the FPGA detector demos and the benches.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 8, width of the repeat counter.
- GAP_W, 4, width of the inter-repetition gap counter.

Ports:
- clk1  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a frame; sampled only in IDLE.
- abort  input  1  synchronous cancel of the frame in progress.
- pattern  input  PAT_W  bit pattern, latched when start is accepted.
- repeat_cnt  input  CNT_W  number of pattern repetitions, latched with pattern.
- gap  input  GAP_W  idle cycles between repetitions, latched with pattern.
- o  output  1  serial data bit; 0 whenever valid=0.
- valid  output  1  o carries a pattern bit this cycle.
- busy  output  1  frame in progress (SEND or GAP).
- done  output  1  one-cycle pulse after the final bit of a completed frame.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; o=0, valid=0, busy=0, done=0; all internal counters and shadow registers cleared.
- All outputs are registered. o changes only on rising clk1, so a detector sampling on the falling edge sees stable data.
- States and transitions:
  - IDLE: start=1 and abort=0 at an edge -> latch pattern/repeat_cnt/gap. If repeat_cnt!=0 go to SEND with bit index PAT_W-1 and reps_left=repeat_cnt. If repeat_cnt==0 go to DONE.
  - SEND: o=shadow[bit_idx], valid=1, busy=1. bit_idx decrements each cycle.
    - After bit 0: reps_left decrements.
    - If reps_left becomes 0 -> DONE.
    - Else if gap!=0 -> GAP with gap_cnt=gap.
    - Else -> SEND at bit_idx=PAT_W-1, back-to-back with no bubble.
  - GAP: o=0, valid=0, busy=1. gap_cnt decrements. On the last gap cycle -> SEND at bit_idx=PAT_W-1.
  - DONE: done=1, busy=0, valid=0 for exactly one cycle -> IDLE. start is ignored in this cycle.
- Latency:
  - start accepted at edge k -> first bit (pattern MSB) on o in the cycle after edge k.
  - Frame length in cycles = repeat_cnt*PAT_W + (repeat_cnt-1)*gap.
  - done is high in the cycle immediately after the last bit.
- start while busy or in DONE: ignored. It is not queued.
- pattern/repeat_cnt/gap changes after acceptance: no effect on the current frame.
- abort=1 in SEND or GAP: next edge -> IDLE, with o=0, valid=0, busy=0 and no done pulse.
- abort=1 in IDLE: no effect. With start=1 in the same cycle, abort wins and the frame is not started.
- abort=1 in DONE: the done pulse still completes.
- Reset mid-frame: immediate return to reset values. The frame is lost and no done pulse is issued.
- Counters never wrap: reps_left and gap_cnt are reloaded, never decremented below 0.
- repeat_cnt at its maximum (all ones) is fully supported.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with start pulsed -> o=0, valid=0, busy=0, done=0 throughout; after release, no activity without start.
- Single frame: PAT_W=4, pattern=4'b1011, repeat_cnt=1, gap=0, start for 1 cycle -> o=1,0,1,1 with valid=1 on cycles 1-4; done=1 on cycle 5 only; busy=1 on cycles 1-4.
- Repeats with gap: pattern=1011, repeat_cnt=3, gap=2 -> o/valid stream is 1011,00,1011,00,1011, with valid=0 on gap cycles; busy for 16 cycles; done on cycle 17.
- Zero repeats and busy-start: repeat_cnt=0 -> done on the cycle after start, valid never high. Separately, re-pulsing start and changing pattern to 0000 mid-frame -> the original 1011 frame completes unchanged and no second frame follows.
- Abort mid-frame: pattern=1011, repeat_cnt=2, abort on the 2nd bit -> the next cycle has valid=0, busy=0 and no done pulse; a new start is then accepted normally.
- Async reset mid-frame: rst_n dropped between edges during a GAP -> outputs clear immediately without waiting for a clock edge; after release, a new frame transmits correctly from its MSB.

Source files
------------

// File: rtl/seq_gen_if.sv
// Control/status bundle between a pattern source and the seq_gen serial transmitter.
// The master drives the frame request; the slave (seq_gen) returns the serial line and status.
interface seq_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             o;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt, gap,
        input  o, valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt, gap,
        output o, valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first, repeated
// repeat_cnt times with an optional idle gap between repetitions; outputs are registered.
module seq_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic     clk1,
    input  logic     rst_n,
    seq_gen_if.slave bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [PAT_W-1:0] shadow_q,    shadow_d;
    logic [IDX_W-1:0] bit_idx_q,   bit_idx_d;
    logic [CNT_W-1:0] reps_left_q, reps_left_d;
    logic [GAP_W-1:0] gap_len_q,   gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic             o_q,         o_d;
    logic             valid_q,     valid_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    // Next-state logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        bit_idx_d   = bit_idx_q;
        reps_left_d = reps_left_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    shadow_d    = bus.pattern;
                    gap_len_d   = bus.gap;
                    reps_left_d = bus.repeat_cnt;
                    bit_idx_d   = IDX_TOP;
                    gap_cnt_d   = {GAP_W{1'b0}};
                    if (bus.repeat_cnt != {CNT_W{1'b0}}) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bit_idx_q != {IDX_W{1'b0}}) begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end else begin
                    // reps_left_q is at least 1 whenever SEND is entered, so this cannot wrap
                    reps_left_d = reps_left_q - CNT_W'(1);
                    if (reps_left_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (gap_len_q != {GAP_W{1'b0}}) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        bit_idx_d = IDX_TOP;
                    end
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = ST_SEND;
                    bit_idx_d = IDX_TOP;
                    gap_cnt_d = {GAP_W{1'b0}};
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_SEND) begin
            o_d     = shadow_d[bit_idx_d];
            valid_d = 1'b1;
        end else begin
            o_d     = 1'b0;
            valid_d = 1'b0;
        end
        busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    // State, counters, shadow copies and registered outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= {PAT_W{1'b0}};
            bit_idx_q   <= {IDX_W{1'b0}};
            reps_left_q <= {CNT_W{1'b0}};
            gap_len_q   <= {GAP_W{1'b0}};
            gap_cnt_q   <= {GAP_W{1'b0}};
            o_q         <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            bit_idx_q   <= bit_idx_d;
            reps_left_q <= reps_left_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            o_q         <= o_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.o     = o_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a frame-stream model (queue of expected per-cycle outputs) checked every
// cycle, directed scenarios pinned by literal expectations, then randomized traffic.
module tb_seq_gen;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic clk1  = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seq_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    // one expected cycle: {o, valid, busy, done}
    typedef struct packed {
        logic o;
        logic valid;
        logic busy;
        logic done;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;

    // Whole frame as a list of cycles: bits, gaps between repetitions, then the done cycle
    function automatic void push_frame(logic [PAT_W-1:0] pat, int rc, int g);
        for (int r = 0; r < rc; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) q.push_back(exp_t'({pat[b], 3'b110}));
            if (r != rc - 1) begin
                for (int k = 0; k < g; k++) q.push_back(exp_t'(4'b0010));
            end
        end
        q.push_back(exp_t'(4'b0001));
    endfunction

    function automatic exp_t model_step();
        exp_t nxt;
        if (cur.busy && bus.abort) begin
            q.delete();
            nxt = '0;
        end else if (q.size() != 0) begin
            nxt = q.pop_front();
        end else if (!cur.done && bus.start && !bus.abort) begin
            push_frame(bus.pattern, int'(bus.repeat_cnt), int'(bus.gap));
            nxt = q.pop_front();
        end else begin
            nxt = '0;
        end
        return nxt;
    endfunction

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur <= '0;
        end else begin
            cur <= model_step();
        end
    end

    always @(negedge clk1) begin
        total = total + 1;
        if ({bus.o, bus.valid, bus.busy, bus.done} !== cur) begin
            bad = bad + 1;
            $display("FAIL stream t=%0t got o/v/b/d=%b want %b", $time,
                     {bus.o, bus.valid, bus.busy, bus.done}, cur);
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endfunction

    task automatic send(input logic [PAT_W-1:0] pat, input int rc, input int g);
        @(negedge clk1);
        bus.pattern    = pat;
        bus.repeat_cnt = CNT_W'(rc);
        bus.gap        = GAP_W'(g);
        bus.start      = 1'b1;
    endtask

    task automatic capture(input int n, output logic [31:0] os, output logic [31:0] vs,
                           output logic [31:0] bs, output logic [31:0] ds);
        os = '0; vs = '0; bs = '0; ds = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk1);
            bus.start = 1'b0;
            os = {os[30:0], bus.o};
            vs = {vs[30:0], bus.valid};
            bs = {bs[30:0], bus.busy};
            ds = {ds[30:0], bus.done};
        end
    endtask

    initial begin
        logic [31:0] os, vs, bs, ds;
        int vcnt, bcnt;
        logic seen;

        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.repeat_cnt = '0; bus.gap = '0;
        #1 rst_n = 1'b0;

        // reset held with start toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            bus.start = ~bus.start;
            check("reset_outs", 32'({bus.o, bus.valid, bus.busy, bus.done}), 32'd0);
        end
        @(negedge clk1);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(negedge clk1);
        check("idle_no_start", 32'({bus.o, bus.valid, bus.busy, bus.done}), 32'd0);

        // single frame
        send(4'b1011, 1, 0);
        capture(5, os, vs, bs, ds);
        check("single_o", os, 32'b10110);
        check("single_valid", vs, 32'b11110);
        check("single_busy", bs, 32'b11110);
        check("single_done", ds, 32'b00001);

        // three repetitions with a two-cycle gap
        send(4'b1011, 3, 2);
        capture(17, os, vs, bs, ds);
        check("rep_o", os, 32'b10110010110010110);
        check("rep_valid", vs, 32'b11110011110011110);
        check("rep_busy", bs, 32'b11111111111111110);
        check("rep_done", ds, 32'b00000000000000001);

        // zero repetitions
        send(4'b1111, 0, 0);
        capture(3, os, vs, bs, ds);
        check("zero_done", ds, 32'b100);
        check("zero_valid", vs, 32'b000);
        check("zero_busy", bs, 32'b000);

        // start re-pulsed while busy and in the done cycle, pattern changed mid-frame
        send(4'b1011, 1, 0);
        os = '0; ds = '0; bs = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk1);
            os = {os[30:0], bus.o};
            ds = {ds[30:0], bus.done};
            bs = {bs[30:0], bus.busy};
            bus.start = (i == 1) || (i == 4);
            if (i == 1) bus.pattern = 4'b0000;
        end
        bus.start = 1'b0;
        check("busystart_o", os, 32'b10110000);
        check("busystart_done", ds, 32'b00001000);
        check("busystart_busy", bs, 32'b11110000);

        // abort on the second bit
        send(4'b1011, 2, 0);
        @(negedge clk1);
        bus.start = 1'b0;
        @(negedge clk1);
        check("abort_bit2", 32'({bus.o, bus.valid}), 32'b01);
        bus.abort = 1'b1;
        @(negedge clk1);
        bus.abort = 1'b0;
        check("abort_next", 32'({bus.valid, bus.busy, bus.done}), 32'd0);
        @(negedge clk1);
        check("abort_no_done", 32'(bus.done), 32'd0);
        send(4'b0110, 1, 0);
        capture(5, os, vs, bs, ds);
        check("after_abort_o", os, 32'b01100);
        check("after_abort_done", ds, 32'b00001);

        // asynchronous reset during a gap
        send(4'b1011, 3, 2);
        capture(5, os, vs, bs, ds);
        check("pre_rst_gap", 32'({bus.valid, bus.busy}), 32'b01);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 32'({bus.o, bus.valid, bus.busy, bus.done}), 32'd0);
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        send(4'b1001, 1, 0);
        capture(5, os, vs, bs, ds);
        check("post_rst_o", os, 32'b10010);
        check("post_rst_done", ds, 32'b00001);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk1);
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.abort      = ($urandom_range(0, 19) == 0);
            bus.pattern    = PAT_W'($urandom);
            bus.repeat_cnt = CNT_W'($urandom_range(0, 4));
            bus.gap        = GAP_W'($urandom_range(0, 3));
        end
        @(negedge clk1);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk1);
        bus.abort = 1'b0;
        @(negedge clk1);

        // maximum repeat count
        send(4'b1101, 255, 1);
        vcnt = 0; bcnt = 0; seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk1);
            bus.start = 1'b0;
            if (bus.valid) vcnt++;
            if (bus.busy) bcnt++;
            if (bus.done) seen = 1'b1;
        end
        check("max_done_seen", 32'(seen), 32'd1);
        check("max_valid_cycles", 32'(vcnt), 32'd1020);
        check("max_busy_cycles", 32'(bcnt), 32'd1274);

        @(negedge clk1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
